// File: rtl/ahb_lite_bus_matrix_mux_pkg.sv
// rtl/ahb_lite_bus_matrix_mux_pkg.sv - shared AHB-Lite types and constants for the bus matrix mux
//
// Purpose: transfer-type and response encodings, default-slave FSM state type,
//          the default-slave read data pattern and an "active transfer" helper.
// Ports:   none (package).

package ahb_lite_bus_matrix_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  localparam logic [31:0] DEADBEEF = 32'hDEADBEEF;

  // NONSEQ and SEQ carry data; IDLE and BUSY must get a zero-wait OKAY.
  function automatic logic is_active(input logic [1:0] trans);
    return (trans == NONSEQ) || (trans == SEQ);
  endfunction

endpackage

// File: rtl/ahb_lite_bus_matrix_mux_if.sv
// rtl/ahb_lite_bus_matrix_mux_if.sv - AHB-Lite master/slave-side signal bundle for the bus matrix mux
//
// Purpose: groups the master address/control, per-slave responses and the
//          muxed response back to the master.
// Signals: HADDR, HTRANS                 master address phase
//          HSEL_SIGNALS                  one-hot slave select (from mux)
//          HREADYOUT_SIGNALS, HRESP_SIGNALS, HRDATA_SIGNALS  per-slave responses,
//                                        slave i read data at [i*DATA_W +: DATA_W]
//          HREADY, HRESP, HRDATA         muxed response to master
// Modports: slave  - the interconnect (acts as the master's slave)
//           master - the environment: master plus the real slaves

interface ahb_lite_bus_matrix_mux_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);

  logic [ADDR_W-1:0]            HADDR;
  logic [1:0]                   HTRANS;
  logic [NUM_SLAVES-1:0]        HSEL_SIGNALS;
  logic [NUM_SLAVES-1:0]        HREADYOUT_SIGNALS;
  logic [NUM_SLAVES-1:0]        HRESP_SIGNALS;
  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_SIGNALS;
  logic                         HREADY;
  logic                         HRESP;
  logic [DATA_W-1:0]            HRDATA;

  modport slave (
    input  HADDR, HTRANS, HREADYOUT_SIGNALS, HRESP_SIGNALS, HRDATA_SIGNALS,
    output HSEL_SIGNALS, HREADY, HRESP, HRDATA
  );

  modport master (
    output HADDR, HTRANS, HREADYOUT_SIGNALS, HRESP_SIGNALS, HRDATA_SIGNALS,
    input  HSEL_SIGNALS, HREADY, HRESP, HRDATA
  );

endinterface

// File: rtl/ahb_lite_bus_matrix_mux_default_slave.sv
// rtl/ahb_lite_bus_matrix_mux_default_slave.sv - default slave answering unmapped transfers with ERROR
//
// Purpose: two-cycle AHB ERROR response for active transfers that hit no slave,
//          plus a saturating count of such transfers.
// Ports:   HCLK, HRESET     clock, synchronous active-high reset
//          HSEL             address phase hit no real slave
//          HTRANS           master transfer type
//          HREADY           bus HREADY; an address is accepted only when high
//          HREADYOUT, HRESP registered default-slave response
//          err_count        saturating unmapped-transfer count

module ahb_default_slave
  import ahb_lite_bus_matrix_mux_pkg::*;
#(
  parameter int ERRCNT_W = 16
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                HSEL,
  input  logic [1:0]          HTRANS,
  input  logic                HREADY,
  output logic                HREADYOUT,
  output logic                HRESP,
  output logic [ERRCNT_W-1:0] err_count
);

  ds_state_t state;
  logic      take_err;

  assign take_err = HREADY & HSEL & is_active(HTRANS);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= DS_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      err_count <= '0;
    end else begin
      case (state)
        // DS_ERR2 is the last data-phase cycle, so a new address may be
        // accepted there exactly as in DS_IDLE; anything else returns to idle,
        // which also covers a master aborting to IDLE.
        DS_IDLE, DS_ERR2: begin
          if (take_err) begin
            state     <= DS_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_ERROR;
            if (err_count != '1) err_count <= err_count + ERRCNT_W'(1);
          end else begin
            state     <= DS_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
          end
        end
        DS_ERR1: begin
          state     <= DS_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_ERROR;
        end
        default: begin
          state     <= DS_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_lite_bus_matrix_mux.sv
// rtl/ahb_lite_bus_matrix_mux.sv - AHB-Lite single-master decoder, response mux and default slave
//
// Purpose: decodes HADDR against a base/mask map (lowest index wins), tracks
//          the data-phase owner and muxes its response back to the master;
//          unmapped active transfers are answered by the default slave.
// Ports:   HCLK, HRESET  clock, synchronous active-high reset
//          bus           ahb_lite_bus_matrix_mux_if.slave bundle
//          err_count     saturating count of unmapped active transfers

module ahb_lite_bus_matrix_mux
  import ahb_lite_bus_matrix_mux_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
    {32'h8000_0000, 32'h0000_1000, 32'h4000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK =
    {32'hF000_0000, 32'hFFFF_F000, 32'hF000_0000, 32'hC000_0000},
  parameter int ERRCNT_W   = 16
) (
  input  logic                HCLK,
  input  logic                HRESET,
  ahb_lite_bus_matrix_mux_if.slave bus,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam logic [NUM_SLAVES:0] DEFAULT_SEL = {1'b1, {NUM_SLAVES{1'b0}}};

  logic [NUM_SLAVES-1:0] match;
  logic [NUM_SLAVES-1:0] hsel;
  logic                  no_match;
  logic [NUM_SLAVES:0]   sel_q;
  logic                  hready;
  logic                  hresp;
  logic [DATA_W-1:0]     hrdata;
  logic                  ds_hreadyout;
  logic                  ds_hresp;

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_decode
    assign match[i] = (bus.HADDR & SLAVE_MASK[i*ADDR_W +: ADDR_W])
                      == SLAVE_BASE[i*ADDR_W +: ADDR_W];
  end

  // Walk from the top index down so the lowest matching slave is written last.
  always_comb begin
    hsel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hsel    = '0;
        hsel[i] = 1'b1;
      end
    end
  end

  assign no_match         = ~|match;
  assign bus.HSEL_SIGNALS = hsel;

  // Data-phase owner: follows the address phase only when the bus is ready.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_q <= DEFAULT_SEL;
    end else if (hready) begin
      sel_q <= {no_match, hsel};
    end
  end

  ahb_default_slave #(
    .ERRCNT_W (ERRCNT_W)
  ) u_default_slave (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (no_match),
    .HTRANS    (bus.HTRANS),
    .HREADY    (hready),
    .HREADYOUT (ds_hreadyout),
    .HRESP     (ds_hresp),
    .err_count (err_count)
  );

  // Anything other than a single real-slave bit (default bit or a corrupt
  // select) is answered by the default slave.
  always_comb begin
    hready = ds_hreadyout;
    hresp  = ds_hresp;
    hrdata = DATA_W'(DEADBEEF);
    if ($onehot(sel_q)) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (sel_q[i]) begin
          hready = bus.HREADYOUT_SIGNALS[i];
          hresp  = bus.HRESP_SIGNALS[i];
          hrdata = bus.HRDATA_SIGNALS[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign bus.HREADY = hready;
  assign bus.HRESP  = hresp;
  assign bus.HRDATA = hrdata;

endmodule

// File: tb/tb_ahb_lite_bus_matrix_mux.sv
// tb/tb_ahb_lite_bus_matrix_mux.sv - self-checking bench for ahb_lite_bus_matrix_mux

module tb_ahb_lite_bus_matrix_mux;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 5;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic [CW-1:0] err_count;

  ahb_lite_bus_matrix_mux_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

  ahb_lite_bus_matrix_mux #(
    .NUM_SLAVES (NS),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .ERRCNT_W   (CW)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .bus       (bus.slave),
    .err_count (err_count)
  );

  always #5 HCLK = ~HCLK;

  // Address map as the system sees it.
  logic [31:0] map_base [NS] = '{32'h0000_0000, 32'h4000_0000, 32'h0000_1000, 32'h8000_0000};
  logic [31:0] map_mask [NS] = '{32'hC000_0000, 32'hF000_0000, 32'hFFFF_F000, 32'hF000_0000};

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: who owns the data phase (-1 = default slave), how far
  // into an error response we are (0 none, 1 first cycle, 2 second), count.
  int tgt    = -1;
  int err_ph = 0;
  int cnt    = 0;
  bit known  = 1'b0;

  logic [31:0] rd [NS];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & map_mask[i]) == map_base[i]) return i;
    return -1;
  endfunction

  task automatic step(input bit rst, input logic [31:0] a, input logic [1:0] tr,
                      input logic [NS-1:0] rdy, input logic [NS-1:0] rsp);
    bit          er;
    bit          es;
    logic [31:0] ed;
    int          d;
    logic [NS-1:0] eh;
    @(negedge HCLK);
    HRESET = rst;
    bus.HADDR = a;
    bus.HTRANS = tr;
    bus.HREADYOUT_SIGNALS = rdy;
    bus.HRESP_SIGNALS = rsp;
    for (int i = 0; i < NS; i++) begin
      rd[i] = $urandom;
      bus.HRDATA_SIGNALS[i*DW +: DW] = rd[i];
    end
    #1;
    d  = decode(a);
    eh = (d < 0) ? '0 : (NS'(1) << d);
    if (tgt >= 0) begin
      er = rdy[tgt];
      es = rsp[tgt];
      ed = rd[tgt];
    end else begin
      er = (err_ph != 1);
      es = (err_ph != 0);
      ed = 32'hDEADBEEF;
    end
    check("hsel", 64'(bus.HSEL_SIGNALS), 64'(eh));
    if (known) begin
      check("hready", 64'(bus.HREADY), 64'(er));
      check("hresp", 64'(bus.HRESP), 64'(es));
      check("hrdata", 64'(bus.HRDATA), 64'(ed));
      check("err_count", 64'(err_count), 64'(cnt));
    end
    @(posedge HCLK);
    if (rst) begin
      tgt = -1; err_ph = 0; cnt = 0; known = 1'b1;
    end else if (er) begin
      if (d < 0 && tr[1]) begin
        tgt = -1; err_ph = 1;
        if (cnt < CNT_MAX) cnt++;
      end else begin
        tgt = d; err_ph = 0;
      end
    end else if (tgt < 0 && err_ph == 1) begin
      err_ph = 2;
    end
  endtask

  initial begin
    // 1: reset for two cycles
    step(1'b1, 32'h0, T_IDLE, '1, '0);
    step(1'b1, 32'h0, T_IDLE, '1, '0);
    #1;
    check("rst_hready", 64'(bus.HREADY), 64'd1);
    check("rst_hresp", 64'(bus.HRESP), 64'd0);
    check("rst_hrdata", 64'(bus.HRDATA), 64'hDEADBEEF);
    check("rst_errcnt", 64'(err_count), 64'd0);

    // 2: transfer to slave 1, then slave 1 stalls three cycles
    step(1'b0, 32'h4000_0010, T_NONSEQ, 4'b1111, 4'b0000);
    #1;
    check("t2_hsel", 64'(bus.HSEL_SIGNALS), 64'b0010);
    check("t2_rdata", 64'(bus.HRDATA), 64'(rd[1]));
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 32'h0000_0040, T_NONSEQ, 4'b1101, 4'b0000);
      #1;
      check("t2_stall", 64'(bus.HREADY), 64'd0);
    end
    step(1'b0, 32'h0000_0040, T_NONSEQ, 4'b1111, 4'b0000);
    step(1'b0, 32'h0000_0040, T_IDLE, 4'b1111, 4'b0000);

    // 3: single unmapped NONSEQ
    step(1'b0, 32'hF000_0000, T_NONSEQ, 4'b1111, 4'b0000);
    #1;
    check("t3_hsel", 64'(bus.HSEL_SIGNALS), 64'd0);
    check("t3_err1_rdy", 64'(bus.HREADY), 64'd0);
    check("t3_err1_rsp", 64'(bus.HRESP), 64'd1);
    step(1'b0, 32'h0000_0000, T_IDLE, 4'b1111, 4'b0000);
    #1;
    check("t3_err2_rdy", 64'(bus.HREADY), 64'd1);
    check("t3_err2_rsp", 64'(bus.HRESP), 64'd1);
    step(1'b0, 32'h0000_0000, T_IDLE, 4'b1111, 4'b0000);
    #1;
    check("t3_okay_rsp", 64'(bus.HRESP), 64'd0);
    check("t3_errcnt", 64'(err_count), 64'd1);

    // 4: back-to-back unmapped, second issued during the ERR2 cycle
    step(1'b0, 32'hF000_0000, T_NONSEQ, 4'b1111, 4'b0000);
    step(1'b0, 32'hF000_0004, T_NONSEQ, 4'b1111, 4'b0000);
    step(1'b0, 32'hF000_0004, T_NONSEQ, 4'b1111, 4'b0000);
    #1;
    check("t4_err1b_rdy", 64'(bus.HREADY), 64'd0);
    step(1'b0, 32'h0000_0000, T_IDLE, 4'b1111, 4'b0000);
    step(1'b0, 32'hF000_0000, T_IDLE, 4'b1111, 4'b0000);
    #1;
    check("t4_errcnt", 64'(err_count), 64'd3);
    step(1'b0, 32'h0000_0000, T_IDLE, 4'b1111, 4'b0000);
    #1;
    check("t4_idle_okay", 64'(bus.HRESP), 64'd0);
    check("t4_idle_cnt", 64'(err_count), 64'd3);

    // 5: overlap of slaves 0 and 2
    step(1'b0, 32'h0000_1000, T_NONSEQ, 4'b1111, 4'b0000);
    #1;
    check("t5_overlap", 64'(bus.HSEL_SIGNALS), 64'b0001);

    // 6: reset while in ERR1, then a normal transfer to slave 0
    step(1'b0, 32'hF000_0000, T_NONSEQ, 4'b1111, 4'b0000);
    step(1'b1, 32'h0000_0000, T_IDLE, 4'b1111, 4'b0000);
    #1;
    check("t6_rdy", 64'(bus.HREADY), 64'd1);
    check("t6_rsp", 64'(bus.HRESP), 64'd0);
    check("t6_cnt", 64'(err_count), 64'd0);
    step(1'b0, 32'h0000_0020, T_NONSEQ, 4'b1111, 4'b0000);
    #1;
    check("t6_rdata", 64'(bus.HRDATA), 64'(rd[0]));
    step(1'b0, 32'h0000_0000, T_IDLE, 4'b1111, 4'b0000);

    // Randomized traffic across mapped, overlapping and unmapped regions
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a;
      logic [NS-1:0] rdy;
      logic [NS-1:0] rsp;
      case ($urandom_range(0, 5))
        0: a = {2'b00, 30'($urandom)};
        1: a = {4'h4, 28'($urandom)};
        2: a = {20'h00001, 12'($urandom)};
        3: a = {4'h8, 28'($urandom)};
        4: a = {4'hF, 28'($urandom)};
        default: a = $urandom;
      endcase
      for (int i = 0; i < NS; i++) rdy[i] = ($urandom_range(0, 3) != 0);
      rsp = NS'($urandom);
      step(($urandom_range(0, 199) == 0), a, 2'($urandom), rdy, rsp);
    end

    // Saturation: continuous unmapped NONSEQ well past the counter range
    step(1'b1, 32'h0, T_IDLE, '1, '0);
    for (int n = 0; n < 2 * (CNT_MAX + 8); n++)
      step(1'b0, 32'hF000_0000, T_NONSEQ, '1, '0);
    #1;
    check("sat_cnt", 64'(err_count), 64'(CNT_MAX));
    step(1'b0, 32'h0, T_IDLE, '1, '0);
    step(1'b0, 32'h0, T_IDLE, '1, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
